// File: rtl/crc_unfold_lfsr_if.sv
// Start/busy/done handshake and data bus of the unfolded CRC generator.
// The master drives the request; the slave returns status and the result.
interface crc_unfold_lfsr_if #(
   parameter int CRC_W = 5,
   parameter int MSG_W = 6
);
   logic             start;
   logic             chain;
   logic [MSG_W-1:0] data_in;
   logic             busy;
   logic             done;
   logic [CRC_W-1:0] crc_out;

   modport master (
      output start, chain, data_in,
      input  busy, done, crc_out
   );

   modport slave (
      input  start, chain, data_in,
      output busy, done, crc_out
   );
endinterface

// File: rtl/crc_unfold_lfsr.sv
// J-unfolded CRC LFSR: one MSG_W-bit word per start, J bits per clock MSB first,
// result = M(x)*x^CRC_W mod G(x), optionally chained from the previous result.
module crc_unfold_lfsr #(
   parameter int               CRC_W = 5,
   parameter logic [CRC_W-1:0] POLY  = 5'b00101,
   parameter int               MSG_W = 6,
   parameter int               J     = 2,
   parameter logic [CRC_W-1:0] INIT  = '0
) (
   input logic               clk,
   input logic               reset,
   crc_unfold_lfsr_if.slave  bus
);

   localparam int N     = MSG_W / J;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   if (J < 1 || J > MSG_W || (MSG_W % J) != 0) begin : g_bad_j
      $error("crc_unfold_lfsr: J must divide MSG_W and lie in 1..MSG_W");
   end

   logic [0:0]       state_q, state_d;
   logic [CRC_W-1:0] s_q, s_d;
   logic [MSG_W-1:0] msg_q, msg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CRC_W-1:0] crc_q, crc_d;
   logic             done_q, done_d;
   logic [CRC_W-1:0] s_step;

   // J serial LFSR steps unrolled into one combinational cone.
   function automatic logic [CRC_W-1:0] step_j(input logic [CRC_W-1:0] s_in,
                                               input logic [J-1:0]     bits);
      logic [CRC_W-1:0] s;
      logic             fb;
      s = s_in;
      for (int i = J - 1; i >= 0; i--) begin
         fb = s[CRC_W-1] ^ bits[i];
         s  = (s << 1) ^ (fb ? POLY : '0);
      end
      return s;
   endfunction

   assign s_step = step_j(s_q, msg_q[MSG_W-1 -: J]);

   always_comb begin
      // NOTE: every output of this block gets a default first so no latch is inferred.
      state_d = state_q;
      s_d     = s_q;
      msg_d   = msg_q;
      cnt_d   = cnt_q;
      crc_d   = crc_q;
      done_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               msg_d   = bus.data_in;
               s_d     = bus.chain ? crc_q : INIT;
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end
         default: begin
            s_d   = s_step;
            msg_d = msg_q << J;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(N - 1)) begin
               crc_d   = s_step;
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
      endcase
   end

   // NOTE: state updates use non-blocking assignments so all flops sample the same edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         s_q     <= '0;
         msg_q   <= '0;
         cnt_q   <= '0;
         crc_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         msg_q   <= msg_d;
         cnt_q   <= cnt_d;
         crc_q   <= crc_d;
         done_q  <= done_d;
      end
   end

   assign bus.busy    = (state_q == S_RUN);
   assign bus.done    = done_q;
   assign bus.crc_out = crc_q;

endmodule

// File: tb/tb_crc_unfold_lfsr.sv
// Bench for crc_unfold_lfsr: random words checked every cycle against a polynomial
// division model, plus directed latency/robustness cases for J = 1, 2 and 3.
module tb_crc_unfold_lfsr;

   localparam int               CRC_W = 5;
   localparam int               MSG_W = 6;
   localparam logic [CRC_W-1:0] POLY  = 5'b00101;
   localparam logic [CRC_W-1:0] INIT  = '0;
   localparam int               N2    = 3;

   logic clk = 1'b0;
   logic reset;
   int   n_cmp  = 0;
   int   n_fail = 0;
   logic mon_en = 1'b0;

   always #5 clk = ~clk;

   crc_unfold_lfsr_if #(.CRC_W(CRC_W), .MSG_W(MSG_W)) bus1 ();
   crc_unfold_lfsr_if #(.CRC_W(CRC_W), .MSG_W(MSG_W)) bus2 ();
   crc_unfold_lfsr_if #(.CRC_W(CRC_W), .MSG_W(MSG_W)) bus3 ();

   crc_unfold_lfsr #(.CRC_W(CRC_W), .POLY(POLY), .MSG_W(MSG_W), .J(2), .INIT(INIT))
      dut2 (.clk(clk), .reset(reset), .bus(bus2));
   crc_unfold_lfsr #(.CRC_W(CRC_W), .POLY(POLY), .MSG_W(MSG_W), .J(1), .INIT(INIT))
      dut1 (.clk(clk), .reset(reset), .bus(bus1));
   crc_unfold_lfsr #(.CRC_W(CRC_W), .POLY(POLY), .MSG_W(MSG_W), .J(3), .INIT(INIT))
      dut3 (.clk(clk), .reset(reset), .bus(bus3));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: (S(x)*x^MSG_W + M(x)*x^CRC_W) mod G(x) by long division.
   function automatic logic [CRC_W-1:0] crc_of(input logic [CRC_W-1:0] init,
                                               input logic [MSG_W-1:0] msg);
      logic [MSG_W+CRC_W-1:0] v;
      logic [MSG_W+CRC_W-1:0] g;
      v = ({msg, {CRC_W{1'b0}}}) ^ ({init, {MSG_W{1'b0}}});
      g = {{(MSG_W-1){1'b0}}, 1'b1, POLY};
      for (int i = MSG_W + CRC_W - 1; i >= CRC_W; i--)
         if (v[i]) v = v ^ (g << (i - CRC_W));
      return v[CRC_W-1:0];
   endfunction

   // Transaction-level model of the J=2 instance: cycles left, pending and last result.
   int               m_rem;
   logic [CRC_W-1:0] m_crc, m_pend;
   logic             m_done;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_rem  <= 0;
         m_crc  <= '0;
         m_pend <= '0;
         m_done <= 1'b0;
      end else begin
         m_done <= 1'b0;
         if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
               m_crc  <= m_pend;
               m_done <= 1'b1;
            end
         end else if (bus2.start) begin
            m_pend <= crc_of(bus2.chain ? m_crc : INIT, bus2.data_in);
            m_rem  <= N2;
         end
      end
   end

   always @(negedge clk) begin
      if (mon_en && !reset) begin
         check("mon_busy", 32'(bus2.busy), 32'(m_rem != 0));
         check("mon_done", 32'(bus2.done), 32'(m_done));
         check("mon_crc",  32'(bus2.crc_out), 32'(m_crc));
      end
   end

   task automatic do_op(input logic [MSG_W-1:0] d, input logic ch);
      bus2.start   = 1'b1;
      bus2.chain   = ch;
      bus2.data_in = d;
      @(negedge clk);
      bus2.start   = 1'b0;
      bus2.data_in = $urandom_range(0, 63);
   endtask

   // Returns the number of clocks after the accepting edge until done, or -1.
   task automatic wait_done(output int lat);
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         bus2.start = 1'b0;
         if (bus2.done) begin
            lat = c;
            break;
         end
      end
   endtask

   initial begin
      int               lat, lat1, lat3, ndone;
      logic [MSG_W-1:0] d;
      logic             ch, pulse;
      logic [CRC_W-1:0] crc1, crc3;

      reset = 1'b1;
      {bus1.start, bus1.chain, bus1.data_in} = '0;
      {bus2.start, bus2.chain, bus2.data_in} = '0;
      {bus3.start, bus3.chain, bus3.data_in} = '0;

      check("model_101011",       32'(crc_of(5'h00, 6'b101011)), 32'h13);
      check("model_111111",       32'(crc_of(5'h00, 6'b111111)), 32'h1D);
      check("model_chain_101011", 32'(crc_of(5'h13, 6'b101011)), 32'h1C);

      repeat (2) @(negedge clk);
      check("rst_busy", 32'(bus2.busy), 32'd0);
      check("rst_done", 32'(bus2.done), 32'd0);
      check("rst_crc",  32'(bus2.crc_out), 32'd0);
      reset  = 1'b0;
      mon_en = 1'b1;
      @(negedge clk);

      do_op(6'b101011, 1'b0);
      check("basic_busy", 32'(bus2.busy), 32'd1);
      wait_done(lat);
      check("basic_lat", 32'(lat), 32'd3);
      check("basic_crc", 32'(bus2.crc_out), 32'h13);

      do_op(6'b101011, 1'b1);
      wait_done(lat);
      check("chain_crc", 32'(bus2.crc_out), 32'h1C);

      do_op(6'b111111, 1'b0);
      wait_done(lat);
      check("ones_crc", 32'(bus2.crc_out), 32'h1D);

      do_op(6'b000000, 1'b0);
      wait_done(lat);
      check("zero_lat", 32'(lat), 32'd3);
      check("zero_crc", 32'(bus2.crc_out), 32'h00);

      // Start pulsed mid-run must be ignored.
      do_op(6'b101011, 1'b0);
      bus2.start   = 1'b1;
      bus2.data_in = 6'b111111;
      wait_done(lat);
      check("midstart_lat", 32'(lat), 32'd3);
      check("midstart_crc", 32'(bus2.crc_out), 32'h13);

      // Start in the done cycle is accepted and chains from the fresh result.
      do_op(6'b101011, 1'b1);
      check("donecyc_busy", 32'(bus2.busy), 32'd1);
      wait_done(lat);
      check("donecyc_crc", 32'(bus2.crc_out), 32'(crc_of(5'h13, 6'b101011)));

      // Reset mid-run: outputs cleared at once, no done afterwards.
      do_op(6'b111111, 1'b0);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("midrst_busy", 32'(bus2.busy), 32'd0);
      check("midrst_done", 32'(bus2.done), 32'd0);
      check("midrst_crc",  32'(bus2.crc_out), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      ndone = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus2.done) ndone++;
      end
      check("midrst_nodone", 32'(ndone), 32'd0);

      // J=1 and J=3 instances: same result, different latency.
      bus1.start = 1'b1; bus1.chain = 1'b0; bus1.data_in = 6'b101011;
      bus3.start = 1'b1; bus3.chain = 1'b0; bus3.data_in = 6'b101011;
      lat1 = -1; lat3 = -1; crc1 = '0; crc3 = '0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         bus1.start = 1'b0;
         bus3.start = 1'b0;
         if (bus1.done && lat1 < 0) begin lat1 = c; crc1 = bus1.crc_out; end
         if (bus3.done && lat3 < 0) begin lat3 = c; crc3 = bus3.crc_out; end
      end
      check("j1_lat", 32'(lat1), 32'd6);
      check("j1_crc", 32'(crc1), 32'h13);
      check("j3_lat", 32'(lat3), 32'd2);
      check("j3_crc", 32'(crc3), 32'h13);

      // Random words, random chaining, gaps and ignored mid-run starts.
      for (int k = 0; k < 150; k++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         d     = MSG_W'($urandom_range(0, 63));
         ch    = 1'($urandom_range(0, 1));
         pulse = ($urandom_range(0, 2) == 0);
         do_op(d, ch);
         if (pulse) begin
            bus2.start   = 1'b1;
            bus2.chain   = 1'($urandom_range(0, 1));
            bus2.data_in = MSG_W'($urandom_range(0, 63));
         end
         wait_done(lat);
         check("rand_lat", 32'(lat), 32'd3);
      end

      repeat (2) @(negedge clk);
      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
